// File: rtl/y_word_if.sv
// Handshake bundle for the packed y-word receive path: packed input side and
// unpacked-field output side. master = word source/consumer environment, slave = unpacker.
interface y_word_if;
  logic        in_valid;
  logic [11:0] in_data;
  logic        in_ready;
  logic        out_valid;
  logic        out_ready;
  logic        out_flag;
  logic [2:0]  out_wire4;
  logic [2:0]  out_reg6;
  logic [3:0]  out_reg5;

  modport master (
    output in_valid, in_data, out_ready,
    input  in_ready, out_valid, out_flag, out_wire4, out_reg6, out_reg5
  );

  modport slave (
    input  in_valid, in_data, out_ready,
    output in_ready, out_valid, out_flag, out_wire4, out_reg6, out_reg5
  );
endinterface

// File: rtl/y_word_unpacker.sv
// Receive side of the 12-bit packed y word: frames are checked, bad words dropped and
// counted, good words unpacked into a small valid/ready FIFO.
module y_word_unpacker #(
  parameter int DEPTH = 4,
  parameter int ERR_W = 8
) (
  input  logic                   clk,
  input  logic                   rst,
  y_word_if.slave                bus,
  output logic                   err_pulse,
  output logic [ERR_W-1:0]       err_cnt,
  output logic [$clog2(DEPTH):0] level
);
  localparam int AW = $clog2(DEPTH);
  localparam int LW = AW + 1;

  // Framing bit is implied by a good frame, so only y[11:1] is stored.
  logic [10:0]   mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [10:0]   head;
  logic          frame_ok;
  logic          accept;
  logic          push;
  logic          pop;
  logic          bad;

  assign frame_ok = !bus.in_data[0] &&
                    (bus.in_data[11] == (bus.in_data[4:1] == 4'h0));

  assign bus.in_ready  = (level != LW'(DEPTH));
  assign bus.out_valid = (level != '0);

  assign accept = bus.in_valid && bus.in_ready;
  assign push   = accept && frame_ok;
  assign bad    = accept && !frame_ok;
  assign pop    = bus.out_valid && bus.out_ready;

  always_ff @(posedge clk) begin
    if (push && !rst) begin
      mem[wr_ptr] <= bus.in_data[11:1];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      level     <= '0;
      err_pulse <= 1'b0;
      err_cnt   <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop)  rd_ptr <= rd_ptr + AW'(1);
      case ({push, pop})
        2'b10:   level <= level + LW'(1);
        2'b01:   level <= level - LW'(1);
        default: level <= level;
      endcase
      err_pulse <= bad;
      if (bad && (err_cnt != '1)) err_cnt <= err_cnt + ERR_W'(1);
    end
  end

  assign head          = mem[rd_ptr];
  assign bus.out_flag  = head[10];
  assign bus.out_wire4 = head[9:7];
  assign bus.out_reg6  = head[6:4];
  assign bus.out_reg5  = head[3:0];
endmodule

// File: tb/tb_y_word_unpacker.sv
// Bench for y_word_unpacker: directed scenarios with literal expectations plus random
// traffic, all checked every cycle against a queue-based model of the receive path.
module tb_y_word_unpacker;
  localparam int DEPTH = 4;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        in_valid = 1'b0;
  logic [11:0] in_data = '0;
  logic        out_ready = 1'b0;

  logic       err_pulse_a, err_pulse_b;
  logic [7:0] err_cnt_a;
  logic [1:0] err_cnt_b;
  logic [2:0] level_a, level_b;

  int total = 0;
  int bad = 0;
  bit started = 1'b0;

  // model state
  logic [11:0] q[$];
  int          m_err = 0;
  bit          m_pulse = 1'b0;

  always #5 clk = ~clk;

  y_word_if bus_a ();
  y_word_if bus_b ();

  assign bus_a.in_valid  = in_valid;
  assign bus_a.in_data   = in_data;
  assign bus_a.out_ready = out_ready;
  assign bus_b.in_valid  = in_valid;
  assign bus_b.in_data   = in_data;
  assign bus_b.out_ready = out_ready;

  y_word_unpacker #(.DEPTH(DEPTH), .ERR_W(8)) dut_a (
    .clk(clk), .rst(rst), .bus(bus_a),
    .err_pulse(err_pulse_a), .err_cnt(err_cnt_a), .level(level_a)
  );

  y_word_unpacker #(.DEPTH(DEPTH), .ERR_W(2)) dut_b (
    .clk(clk), .rst(rst), .bus(bus_b),
    .err_pulse(err_pulse_b), .err_cnt(err_cnt_b), .level(level_b)
  );

  task automatic chk(input string name, input int act, input int exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got=%0d expected=%0d at %0t", name, act, exp, $time);
    end
  endtask

  function automatic bit good_frame(input logic [11:0] d);
    return (d[0] == 1'b0) && (d[11] == (d[4:1] == 4'h0));
  endfunction

  // Reference: FIFO as a queue of accepted good words, error count as plain integer.
  always @(posedge clk) begin
    if (rst) begin
      q.delete();
      m_err   = 0;
      m_pulse = 1'b0;
    end else begin
      bit acc, popd, ok;
      acc  = in_valid && (q.size() < DEPTH);
      ok   = good_frame(in_data);
      popd = (q.size() > 0) && out_ready;
      if (popd) void'(q.pop_front());
      if (acc && ok) q.push_back(in_data);
      m_pulse = acc && !ok;
      if (m_pulse) m_err++;
    end
  end

  always @(negedge clk) begin
    if (started) begin
      chk("in_ready", int'(bus_a.in_ready), int'(q.size() != DEPTH));
      chk("out_valid", int'(bus_a.out_valid), int'(q.size() != 0));
      chk("level", int'(level_a), q.size());
      chk("err_pulse", int'(err_pulse_a), int'(m_pulse));
      chk("err_cnt8", int'(err_cnt_a), (m_err > 255) ? 255 : m_err);
      chk("level_b", int'(level_b), q.size());
      chk("err_pulse_b", int'(err_pulse_b), int'(m_pulse));
      chk("err_cnt2", int'(err_cnt_b), (m_err > 3) ? 3 : m_err);
      if (q.size() > 0) begin
        chk("fields", int'({bus_a.out_flag, bus_a.out_wire4, bus_a.out_reg6, bus_a.out_reg5}),
            int'(q[0][11:1]));
        chk("fields_b", int'({bus_b.out_flag, bus_b.out_wire4, bus_b.out_reg6, bus_b.out_reg5}),
            int'(q[0][11:1]));
      end
    end
  end

  // Inputs change on the falling edge; returns on the next falling edge.
  task automatic drive(input bit v, input logic [11:0] d, input bit r);
    in_valid  = v;
    in_data   = d;
    out_ready = r;
    @(negedge clk);
  endtask

  task automatic do_rst();
    rst = 1'b1;
    drive(1'b0, 12'h000, 1'b0);
    rst = 1'b0;
  endtask

  task automatic fields(input string name, input int f, input int w4, input int r6, input int r5);
    chk({name, ".flag"}, int'(bus_a.out_flag), f);
    chk({name, ".wire4"}, int'(bus_a.out_wire4), w4);
    chk({name, ".reg6"}, int'(bus_a.out_reg6), r6);
    chk({name, ".reg5"}, int'(bus_a.out_reg5), r5);
  endtask

  initial begin
    logic [11:0] d;
    @(negedge clk);
    do_rst();
    started = 1'b1;

    // single good word
    chk("t1.reset_level", int'(level_a), 0);
    drive(1'b1, 12'h800, 1'b0);
    chk("t1.out_valid", int'(bus_a.out_valid), 1);
    fields("t1", 1, 0, 0, 0);
    chk("t1.level", int'(level_a), 1);
    chk("t1.err_cnt", int'(err_cnt_a), 0);
    drive(1'b0, 12'h000, 1'b1);
    chk("t1.drained", int'(level_a), 0);

    // unpack and order
    drive(1'b1, 12'h0A6, 1'b0);
    chk("t2.level1", int'(level_a), 1);
    drive(1'b1, 12'h7E4, 1'b0);
    chk("t2.level2", int'(level_a), 2);
    fields("t2.pop1", 0, 0, 5, 3);
    drive(1'b0, 12'h000, 1'b1);
    chk("t2.level3", int'(level_a), 1);
    fields("t2.pop2", 0, 7, 7, 2);
    drive(1'b0, 12'h000, 1'b1);
    chk("t2.level4", int'(level_a), 0);

    // framing errors and saturation
    do_rst();
    begin
      logic [11:0] badw[5];
      int exp_b[5];
      badw = '{12'h001, 12'h000, 12'h802, 12'hFFF, 12'h0A7};
      exp_b = '{1, 2, 3, 3, 3};
      for (int i = 0; i < 5; i++) begin
        drive(1'b1, badw[i], 1'b0);
        chk("t3.pulse", int'(err_pulse_a), 1);
        chk("t3.cnt8", int'(err_cnt_a), i + 1);
        chk("t3.cnt2", int'(err_cnt_b), exp_b[i]);
        chk("t3.out_valid", int'(bus_a.out_valid), 0);
      end
      drive(1'b0, 12'h000, 1'b0);
      chk("t3.pulse_end", int'(err_pulse_a), 0);
    end

    // full backpressure
    do_rst();
    drive(1'b1, 12'h0A6, 1'b0);
    drive(1'b1, 12'h7E4, 1'b0);
    drive(1'b1, 12'h800, 1'b0);
    drive(1'b1, 12'h112, 1'b0);
    chk("t4.full_ready", int'(bus_a.in_ready), 0);
    chk("t4.full_level", int'(level_a), 4);
    drive(1'b1, 12'h35C, 1'b0);
    drive(1'b1, 12'h35C, 1'b0);
    chk("t4.held_level", int'(level_a), 4);
    chk("t4.held_err", int'(err_cnt_a), 0);
    drive(1'b1, 12'h35C, 1'b1);
    chk("t4.pop_level", int'(level_a), 3);
    chk("t4.pop_ready", int'(bus_a.in_ready), 1);
    fields("t4.head", 0, 7, 7, 2);
    drive(1'b1, 12'h35C, 1'b0);
    chk("t4.refill", int'(level_a), 4);
    for (int i = 0; i < 4; i++) drive(1'b0, 12'h000, 1'b1);
    chk("t4.drained", int'(level_a), 0);

    // reset mid-operation
    drive(1'b1, 12'h0A6, 1'b0);
    drive(1'b1, 12'h7E4, 1'b0);
    drive(1'b1, 12'h001, 1'b0);
    drive(1'b1, 12'h000, 1'b0);
    drive(1'b1, 12'h800, 1'b0);
    chk("t6.pre_level", int'(level_a), 3);
    chk("t6.pre_err", int'(err_cnt_a), 2);
    rst = 1'b1;
    drive(1'b1, 12'h0A6, 1'b0);
    rst = 1'b0;
    chk("t6.level", int'(level_a), 0);
    chk("t6.out_valid", int'(bus_a.out_valid), 0);
    chk("t6.err", int'(err_cnt_a), 0);
    chk("t6.in_ready", int'(bus_a.in_ready), 1);
    drive(1'b1, 12'h800, 1'b0);
    fields("t6.word", 1, 0, 0, 0);
    chk("t6.level1", int'(level_a), 1);

    // random traffic
    for (int n = 0; n < 3000; n++) begin
      d = 12'($urandom);
      if ($urandom_range(0, 3) != 0) begin
        d[0]  = 1'b0;
        d[11] = (d[4:1] == 4'h0);
      end
      rst = ($urandom_range(0, 199) == 0);
      drive($urandom_range(0, 9) < 7, d, $urandom_range(0, 9) < 5);
      rst = 1'b0;
    end

    drive(1'b0, 12'h000, 1'b0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/y_word_unpacker.md
Name: y_word_unpacker

Overview:
- Receive side of the 12-bit packed status word `y`. The word layout is:
  - y[11] = zero-flag
  - y[10:8] = wire4
  - y[7:5] = reg6
  - y[4:1] = reg5
  - y[0] = framing 0
- The block checks each word, drops malformed words and counts them.
- Good words are unpacked into separate fields and buffered in a small FIFO with valid/ready on both sides.
- It sits between the packed-word source and downstream consumers and monitors the link.

Parameters:
- DEPTH, 4: FIFO entries; power of two, minimum 2.
- ERR_W, 8: width of the saturating error counter.

Ports:
- clk, input, 1: rising-edge clock.
- rst, input, 1: synchronous, active-high reset.
- in_valid, input, 1: in_data is valid this cycle.
- in_data, input, 12: packed word.
- in_ready, output, 1: block can accept a word this cycle.
- out_valid, output, 1: FIFO head is valid.
- out_ready, input, 1: consumer takes the head.
- out_flag, output, 1: zero-flag field (y[11]).
- out_wire4, output, 3: y[10:8].
- out_reg6, output, 3: y[7:5].
- out_reg5, output, 4: y[4:1].
- err_pulse, output, 1: one-cycle pulse; a malformed word was dropped.
- err_cnt, output, ERR_W: saturating count of dropped words.
- level, output, clog2(DEPTH)+1: FIFO occupancy.

Behaviour:
- Reset (rst=1 at a clock edge):
  - FIFO pointers and level go to 0; out_valid=0; err_pulse=0; err_cnt=0.
  - FIFO storage is not cleared. Field outputs are don't-care while out_valid=0.
  - Reset overrides any push or pop in the same cycle. A word in flight during reset is lost and is not counted.
- Handshakes:
  - in_ready = (level != DEPTH). It is combinational from registered state and never depends on in_valid.
  - Accept happens when in_valid && in_ready at a clock edge.
  - Pop happens when out_valid && out_ready at a clock edge.
  - out_valid = (level != 0).
- Word check, combinational on in_data:
  - frame_ok = (in_data[0]==0) && (in_data[11] == (in_data[4:1]==4'h0)).
- Accepted word with frame_ok=1:
  - Written to FIFO at wr_ptr; wr_ptr++ (wraps modulo DEPTH).
- Accepted word with frame_ok=0:
  - Dropped, with no FIFO write.
  - err_pulse=1 in the following cycle.
  - err_cnt increments and holds at 2^ERR_W-1 (no wrap).
- Malformed words are still subject to in_ready. When the FIFO is full they are not accepted and not counted.
- Field outputs:
  - Driven from the entry at rd_ptr; valid whenever out_valid=1.
  - They must remain stable while out_valid=1 and out_ready=0.
- Latency: a word accepted at edge N appears on the outputs with out_valid=1 after edge N. There is no combinational in-to-out path.
- Level update:
  - push only: +1
  - pop only: −1
  - push and pop in the same edge: unchanged, both pointers advance
  - neither: unchanged
- Full (level=DEPTH): in_ready=0, even if out_ready=1 that cycle; there is no bypass.
- Empty (level=0): out_valid=0; out_ready is ignored.
- FIFO order is strict: words leave in acceptance order.
- All outputs except in_ready and the field/valid outputs are registered.

Test Plan:
1. Single good word: after reset, in_data=12'h800 for one cycle with out_ready=0 → next cycle out_valid=1, out_flag=1, wire4=0, reg6=0, reg5=0, level=1, err_cnt=0.
2. Field unpack and order: send 12'h0A6 then 12'h7E4 back-to-back, then set out_ready=1.
   - First pop: flag=0, wire4=0, reg6=5, reg5=3.
   - Second pop: flag=0, wire4=7, reg6=7, reg5=2.
   - level steps 1→2→1→0.
3. Framing errors: send 12'h001 (bit0 set), 12'h000 (reg5=0 but flag=0) and 12'h802 (reg5≠0 but flag=1) → three err_pulse cycles, err_cnt=3, level stays 0, out_valid stays 0.
4. Full backpressure, DEPTH=4:
   - Push 5 good words with out_ready=0 → in_ready=0 after the 4th accept; the 5th is held and not lost or counted.
   - Raise out_ready → one pop, then the 5th word is accepted next cycle; level returns to 4.
5. Saturation with ERR_W=2: send 5 malformed words → err_cnt sequence 1,2,3,3,3; five err_pulse cycles.
6. Reset mid-operation:
   - Fill 3 entries with err_cnt=2, then assert rst for 1 cycle while in_valid=1.
   - Next cycle: level=0, out_valid=0, err_cnt=0, in_ready=1.
   - A subsequent word 12'h800 is unpacked correctly.
